// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter slice.
// Contents: FSM state encoding, transaction owner encoding, data widths,
// starvation counter width and the fetch word-select helper.
package mem_port_arbiter_pkg;

    localparam int MEM_DATA_W = 64;
    localparam int IF_WORD_W  = 32;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Instruction words are 32 bits inside a 64-bit memory beat; address
    // bit 2 picks the half.
    function automatic logic [IF_WORD_W-1:0] select_word(
        input logic [MEM_DATA_W-1:0] data,
        input logic                  upper
    );
        return upper ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of all handshake and bus signals around the memory port arbiter.
// Ports: none (pure signal bundle), parameter ADDR_W sets address widths.
// Modports:
//   master - the arbiter: accepts IF/D requests, drives the memory request
//            and routes responses back.
//   slave  - the environment: fetch stage, load/store stage and memory.
// Handshake: a request transfers in the cycle where *_req_valid and
// *_req_ready are both 1; the requester holds its payload stable while
// valid is high and ready is low. Ready and response valids are one-cycle
// pulses. mem_req_valid is held with a stable payload until mem_req_ready;
// mem_resp_valid is always accepted (no backpressure).
interface mem_port_arbiter_if #(parameter int ADDR_W = 32);

    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_kill;
    logic              if_resp_valid;
    logic [31:0]       if_rdata;

    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [63:0]       d_wdata;
    logic [7:0]        d_wmask;
    logic              d_resp_valid;
    logic [63:0]       d_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [7:0]        mem_wmask;
    logic              mem_resp_valid;
    logic [63:0]       mem_rdata;

    modport master (
        input  if_req_valid, if_addr, if_kill,
        input  d_req_valid, d_wen, d_addr, d_wdata, d_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output if_req_ready, if_resp_valid, if_rdata,
        output d_req_ready, d_resp_valid, d_rdata,
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        output if_req_valid, if_addr, if_kill,
        output d_req_valid, d_wen, d_addr, d_wdata, d_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  if_req_ready, if_resp_valid, if_rdata,
        input  d_req_ready, d_resp_valid, d_rdata,
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Grant decision and starvation counter next-state for the memory arbiter.
// Ports:
//   idle          in  arbiter is free to grant this cycle
//   if_req_valid  in  fetch request
//   if_kill       in  fetch kill (blocks the fetch grant)
//   d_req_valid   in  data request
//   cnt           in  current starvation count
//   grant_d       out data request wins
//   grant_if      out fetch request wins
//   cnt_next      out next starvation count
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             idle,
    input  logic             if_req_valid,
    input  logic             if_kill,
    input  logic             d_req_valid,
    input  logic [CNT_W-1:0] cnt,
    output logic             grant_d,
    output logic             grant_if,
    output logic [CNT_W-1:0] cnt_next
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic if_live;
    logic if_starved;

    always_comb begin
        if_live    = if_req_valid && !if_kill;
        // Data normally wins; once fetch has lost LIMIT times in a row it wins.
        if_starved = if_live && (cnt == LIMIT);
        grant_d    = idle && d_req_valid && !if_starved;
        grant_if   = idle && !grant_d && if_live;

        cnt_next = cnt;
        if (idle) begin
            if (grant_if || !if_req_valid) begin
                cnt_next = '0;
            end else if (grant_d && if_live && (cnt != LIMIT)) begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction fetch (IF) and
// load/store (D), with one outstanding transaction at a time. Data has
// priority; fetch is forced through after STARVE_LIMIT consecutive losses.
// Killed fetches still complete on the memory side but their response is
// dropped.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   bus            arbiter side (master modport) of mem_port_arbiter_if
//   dbg_state      current FSM state
//   dbg_starve_cnt current starvation counter
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus,
    output arb_state_t         dbg_state,
    output logic [CNT_W-1:0]   dbg_starve_cnt
);

    arb_state_t              state_q;
    owner_t                  owner_q;
    logic                    killed_q;
    logic                    wen_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [MEM_DATA_W-1:0]   wdata_q;
    logic [7:0]              wmask_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_next;
    logic                    grant_d;
    logic                    grant_if;
    logic                    idle;
    logic                    resp_cycle;
    logic                    d_resp;
    logic                    if_resp;

    // Gating with rst keeps every valid/ready at 0 while reset is held,
    // even if the state register still holds a mid-transaction value.
    assign idle = !rst && (state_q == IDLE);

    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .idle         (idle),
        .if_req_valid (bus.if_req_valid),
        .if_kill      (bus.if_kill),
        .d_req_valid  (bus.d_req_valid),
        .cnt          (cnt_q),
        .grant_d      (grant_d),
        .grant_if     (grant_if),
        .cnt_next     (cnt_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            killed_q <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_next;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        owner_q  <= OWN_D;
                        killed_q <= 1'b0;
                        wen_q    <= bus.d_wen;
                        addr_q   <= bus.d_addr;
                        wdata_q  <= bus.d_wdata;
                        wmask_q  <= bus.d_wmask;
                        state_q  <= REQ;
                    end else if (grant_if) begin
                        owner_q  <= OWN_IF;
                        killed_q <= 1'b0;
                        wen_q    <= 1'b0;
                        addr_q   <= bus.if_addr;
                        wdata_q  <= '0;
                        wmask_q  <= '0;
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (owner_q == OWN_IF && bus.if_kill) killed_q <= 1'b1;
                    if (bus.mem_req_ready) state_q <= WAIT;
                end
                WAIT: begin
                    if (owner_q == OWN_IF && bus.if_kill) killed_q <= 1'b1;
                    if (bus.mem_resp_valid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A response outside WAIT is a protocol error and is ignored.
    assign resp_cycle = !rst && (state_q == WAIT) && bus.mem_resp_valid;
    assign d_resp     = resp_cycle && (owner_q == OWN_D);
    // A kill arriving in the response cycle itself also drops the response.
    assign if_resp    = resp_cycle && (owner_q == OWN_IF) && !killed_q && !bus.if_kill;

    assign bus.if_req_ready  = grant_if;
    assign bus.d_req_ready   = grant_d;
    assign bus.mem_req_valid = !rst && (state_q == REQ);
    assign bus.mem_wen       = wen_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;
    assign bus.d_resp_valid  = d_resp;
    assign bus.d_rdata       = d_resp ? bus.mem_rdata : '0;
    assign bus.if_resp_valid = if_resp;
    assign bus.if_rdata      = if_resp ? select_word(bus.mem_rdata, addr_q[2]) : '0;

    assign dbg_state      = state_q;
    assign dbg_starve_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       rst;
    arb_state_t dbg_state;
    logic [3:0] dbg_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter_if #(.ADDR_W(32)) m ();

    mem_port_arbiter #(.ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (m.master),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m.if_req_valid = 0; m.if_addr = '0; m.if_kill = 0;
        m.d_req_valid = 0; m.d_wen = 0; m.d_addr = '0; m.d_wdata = '0; m.d_wmask = '0;
        m.mem_req_ready = 0; m.mem_resp_valid = 0; m.mem_rdata = '0;
    endtask

    // Called in a cycle where a request is presented downstream: accept it,
    // answer on the next cycle, return in the following (IDLE) cycle.
    task automatic finish_txn(input logic [63:0] rdata);
        m.mem_req_ready = 1;
        @(negedge clk);
        chk("txn_mem_valid", 64'(m.mem_req_valid), 64'd1);
        tick();
        m.mem_req_ready = 0; m.mem_resp_valid = 1; m.mem_rdata = rdata;
        @(negedge clk);
        tick();
        m.mem_resp_valid = 0;
    endtask

    // ---------------- reference model ----------------
    // Transaction view: phase 0 = free, 1 = request offered downstream,
    // 2 = awaiting the response.
    int          md_phase  = 0;
    bit          md_own_d  = 0;
    bit          md_killed = 0;
    int          md_starve = 0;
    logic        md_wen;
    logic [31:0] md_addr;
    logic [63:0] md_wdata;
    logic [7:0]  md_wmask;
    bit          e_live, e_gd, e_gif, e_dr, e_ir;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_if_ready", 64'(m.if_req_ready), 64'd0);
            chk("rst_d_ready", 64'(m.d_req_ready), 64'd0);
            chk("rst_mem_valid", 64'(m.mem_req_valid), 64'd0);
            chk("rst_if_resp", 64'(m.if_resp_valid), 64'd0);
            chk("rst_d_resp", 64'(m.d_resp_valid), 64'd0);
            md_phase = 0; md_starve = 0; md_killed = 0;
        end else begin
            e_live = m.if_req_valid && !m.if_kill;
            e_gd   = (md_phase == 0) && m.d_req_valid && !(e_live && md_starve == LIMIT);
            e_gif  = (md_phase == 0) && !e_gd && e_live;
            e_dr   = (md_phase == 2) && m.mem_resp_valid && md_own_d;
            e_ir   = (md_phase == 2) && m.mem_resp_valid && !md_own_d && !md_killed && !m.if_kill;

            chk("m_state", 64'(dbg_state), 64'(md_phase));
            chk("m_cnt", 64'(dbg_cnt), 64'(md_starve));
            chk("m_if_ready", 64'(m.if_req_ready), 64'(e_gif));
            chk("m_d_ready", 64'(m.d_req_ready), 64'(e_gd));
            chk("m_mem_valid", 64'(m.mem_req_valid), 64'(md_phase == 1));
            if (md_phase == 1) begin
                chk("m_mem_wen", 64'(m.mem_wen), 64'(md_wen));
                chk("m_mem_addr", 64'(m.mem_addr), 64'(md_addr));
                chk("m_mem_wdata", m.mem_wdata, md_wdata);
                chk("m_mem_wmask", 64'(m.mem_wmask), 64'(md_wmask));
            end
            chk("m_d_resp", 64'(m.d_resp_valid), 64'(e_dr));
            chk("m_if_resp", 64'(m.if_resp_valid), 64'(e_ir));
            if (e_dr) chk("m_d_rdata", m.d_rdata, m.mem_rdata);
            if (e_ir) chk("m_if_rdata", 64'(m.if_rdata),
                          md_addr[2] ? 64'(m.mem_rdata[63:32]) : 64'(m.mem_rdata[31:0]));

            // advance the model with this cycle's inputs
            if (md_phase == 0) begin
                if (e_gif || !m.if_req_valid) md_starve = 0;
                else if (e_gd && e_live && md_starve < LIMIT) md_starve++;
                if (e_gd) begin
                    md_phase = 1; md_own_d = 1; md_killed = 0;
                    md_wen = m.d_wen; md_addr = m.d_addr; md_wdata = m.d_wdata; md_wmask = m.d_wmask;
                end else if (e_gif) begin
                    md_phase = 1; md_own_d = 0; md_killed = 0;
                    md_wen = 0; md_addr = m.if_addr; md_wdata = '0; md_wmask = '0;
                end
            end else begin
                if (!md_own_d && m.if_kill) md_killed = 1;
                if (md_phase == 1 && m.mem_req_ready) md_phase = 2;
                else if (md_phase == 2 && m.mem_resp_valid) md_phase = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) assert (!(m.mem_resp_valid && dbg_state != WAIT))
            else $error("memory response outside WAIT");
    end

    // ---------------- directed stimulus ----------------
    int   dg;
    bit   if_granted;
    bit   acc;

    initial begin
        idle_inputs();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        @(negedge clk);
        chk("reset_state", 64'(dbg_state), 64'd0);
        chk("reset_cnt", 64'(dbg_cnt), 64'd0);
        chk("reset_mem_valid", 64'(m.mem_req_valid), 64'd0);
        chk("reset_mem_addr", 64'(m.mem_addr), 64'd0);
        tick();

        // 1: single fetch, upper word selected by addr[2]
        m.if_req_valid = 1; m.if_addr = 32'h8000_0004; m.mem_req_ready = 1;
        @(negedge clk); chk("t1_if_ready", 64'(m.if_req_ready), 64'd1);
        tick(); m.if_req_valid = 0;
        @(negedge clk); chk("t1_mem_valid", 64'(m.mem_req_valid), 64'd1);
        tick(); m.mem_req_ready = 0; m.mem_resp_valid = 1; m.mem_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        chk("t1_if_resp", 64'(m.if_resp_valid), 64'd1);
        chk("t1_if_rdata", 64'(m.if_rdata), 64'h1111_2222);
        chk("t1_d_resp", 64'(m.d_resp_valid), 64'd0);
        tick(); m.mem_resp_valid = 0;
        tick();

        // 2: simultaneous IF and D, D store wins
        m.if_req_valid = 1; m.if_addr = 32'h0000_0100;
        m.d_req_valid = 1; m.d_wen = 1; m.d_addr = 32'h0000_2000;
        m.d_wdata = 64'hDEAD_BEEF; m.d_wmask = 8'h0F;
        @(negedge clk);
        chk("t2_d_ready", 64'(m.d_req_ready), 64'd1);
        chk("t2_if_ready", 64'(m.if_req_ready), 64'd0);
        tick(); m.d_req_valid = 0; m.mem_req_ready = 1;
        @(negedge clk);
        chk("t2_mem_wen", 64'(m.mem_wen), 64'd1);
        chk("t2_mem_wmask", 64'(m.mem_wmask), 64'h0F);
        chk("t2_mem_wdata", m.mem_wdata, 64'hDEAD_BEEF);
        tick(); m.mem_req_ready = 0; m.mem_resp_valid = 1; m.mem_rdata = 64'h5;
        @(negedge clk);
        chk("t2_d_resp", 64'(m.d_resp_valid), 64'd1);
        chk("t2_no_grant_in_resp", 64'(m.if_req_ready), 64'd0);
        tick(); m.mem_resp_valid = 0;
        @(negedge clk); chk("t2_if_ready_after", 64'(m.if_req_ready), 64'd1);
        tick(); m.if_req_valid = 0;
        finish_txn(64'h0123_4567_89AB_CDEF);
        tick();

        // 3: starvation, fetch held while data streams
        m.if_req_valid = 1; m.if_addr = 32'h0000_0040;
        m.d_req_valid = 1; m.d_wen = 0; m.d_addr = 32'h0000_1000; m.mem_req_ready = 1;
        dg = 0; if_granted = 0;
        for (int c = 0; c < 60 && !if_granted; c++) begin
            @(negedge clk);
            acc = m.mem_req_valid && m.mem_req_ready;
            if (m.d_req_ready) dg++;
            if (m.if_req_ready) if_granted = 1;
            tick();
            m.mem_resp_valid = acc;
            m.mem_rdata = {$urandom, $urandom};
            m.d_addr = 32'h0000_1000 + 32'(dg * 8);
        end
        chk("t3_if_granted", 64'(if_granted), 64'd1);
        chk("t3_d_grants", 64'(dg), 64'd4);
        m.if_req_valid = 0; m.d_req_valid = 0;
        @(negedge clk);
        chk("t3_cnt_cleared", 64'(dbg_cnt), 64'd0);
        chk("t3_mem_addr", 64'(m.mem_addr), 64'h40);
        tick(); m.mem_resp_valid = 1; m.mem_rdata = 64'hAAAA_0000_BBBB_1111;
        @(negedge clk); chk("t3_if_rdata", 64'(m.if_rdata), 64'hBBBB_1111);
        tick(); m.mem_resp_valid = 0; m.mem_req_ready = 0;
        tick();

        // 4: kill while waiting for the response
        m.if_req_valid = 1; m.if_addr = 32'h8000_0010; m.mem_req_ready = 1;
        @(negedge clk); chk("t4_if_ready", 64'(m.if_req_ready), 64'd1);
        tick(); m.if_req_valid = 0;
        @(negedge clk);
        tick(); m.mem_req_ready = 0; m.if_kill = 1;
        @(negedge clk);
        tick(); m.if_kill = 0;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick(); m.mem_resp_valid = 1; m.mem_rdata = 64'h7777_8888_9999_AAAA;
        @(negedge clk); chk("t4_no_if_resp", 64'(m.if_resp_valid), 64'd0);
        tick(); m.mem_resp_valid = 0;
        m.d_req_valid = 1; m.d_wen = 0; m.d_addr = 32'h0000_3000;
        @(negedge clk);
        chk("t4_idle", 64'(dbg_state), 64'd0);
        chk("t4_d_ready", 64'(m.d_req_ready), 64'd1);
        tick(); m.d_req_valid = 0;
        finish_txn(64'h1);
        tick();

        // 5: data load under downstream backpressure
        m.d_req_valid = 1; m.d_wen = 0; m.d_addr = 32'h0000_4008;
        @(negedge clk); chk("t5_d_ready", 64'(m.d_req_ready), 64'd1);
        tick(); m.d_req_valid = 0; m.d_addr = 32'h0000_FFF0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_hold_valid", 64'(m.mem_req_valid), 64'd1);
            chk("t5_hold_addr", 64'(m.mem_addr), 64'h4008);
            chk("t5_hold_wen", 64'(m.mem_wen), 64'd0);
            tick();
        end
        m.mem_req_ready = 1;
        @(negedge clk);
        tick(); m.mem_req_ready = 0;
        @(negedge clk); chk("t5_wait", 64'(dbg_state), 64'd2);
        tick(); m.mem_resp_valid = 1; m.mem_rdata = 64'hCAFE_F00D_1234_5678;
        @(negedge clk);
        chk("t5_d_resp", 64'(m.d_resp_valid), 64'd1);
        chk("t5_d_rdata", m.d_rdata, 64'hCAFE_F00D_1234_5678);
        tick(); m.mem_resp_valid = 0;
        tick();

        // 6: reset in the middle of a fetch
        m.if_req_valid = 1; m.if_addr = 32'h0000_0200;
        @(negedge clk);
        tick(); m.if_req_valid = 0;
        @(negedge clk); chk("t6_in_req", 64'(dbg_state), 64'd1);
        tick(); rst = 1;
        @(negedge clk);
        tick(); rst = 0;
        @(negedge clk);
        chk("t6_idle", 64'(dbg_state), 64'd0);
        chk("t6_cnt", 64'(dbg_cnt), 64'd0);
        chk("t6_mem_valid", 64'(m.mem_req_valid), 64'd0);
        tick();
        m.if_req_valid = 1; m.if_addr = 32'h0000_0204; m.mem_req_ready = 1;
        @(negedge clk); chk("t6_if_ready", 64'(m.if_req_ready), 64'd1);
        tick(); m.if_req_valid = 0;
        @(negedge clk);
        tick(); m.mem_req_ready = 0; m.mem_resp_valid = 1; m.mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        @(negedge clk);
        chk("t6_if_resp", 64'(m.if_resp_valid), 64'd1);
        chk("t6_if_rdata", 64'(m.if_rdata), 64'hAAAA_BBBB);
        tick(); m.mem_resp_valid = 0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one downstream memory port between two requesters: the instruction-fetch stage (IF) and the load/store stage (MEM).
- Allows exactly one outstanding transaction. Data requests have priority over fetch, with a bounded-starvation guarantee for fetch.
- Responses go back only to the owner of the transaction.
- A killed fetch (taken branch/jump redirect) still completes on the memory side, but its response is dropped.

Parameters:
- ADDR_W, 32, address width of all address ports
- STARVE_LIMIT, 4, max consecutive data grants while fetch is pending before fetch is forced to win (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted (one-cycle pulse)
- if_addr  in  ADDR_W  fetch address, 4-byte aligned
- if_kill  in  1  discard the current/outstanding fetch
- if_resp_valid  out  1  fetch data valid (one-cycle pulse)
- if_rdata  out  32  instruction word
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted (one-cycle pulse)
- d_wen  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  64  store data
- d_wmask  in  8  store byte mask
- d_resp_valid  out  1  data response (load data, or store acknowledge)
- d_rdata  out  64  load data
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts request
- mem_wen  out  1  downstream write
- mem_addr  out  ADDR_W  downstream address
- mem_wdata  out  64  downstream write data
- mem_wmask  out  8  downstream byte mask
- mem_resp_valid  in  1  downstream response; always accepted, no backpressure
- mem_rdata  in  64  downstream read data

Behaviour:
- States: IDLE, REQ, WAIT. Registered fields: owner (IF/D), killed flag, latched payload, starvation counter (4 bits).
- Reset values: state=IDLE, counter=0, killed=0. All valid/ready outputs are 0. mem_* payload and rdata outputs are 0.
- IDLE arbitration, combinational, in the same cycle:
  - grant D if d_req_valid and NOT (if_req_valid && !if_kill && counter==STARVE_LIMIT);
  - otherwise grant IF if if_req_valid && !if_kill;
  - otherwise stay IDLE.
  - The granted source gets its *_req_ready=1 this cycle. The payload is latched, owner is set, killed is cleared, and state moves to REQ.
- Counter:
  - increments on a D grant while if_req_valid && !if_kill, saturating at STARVE_LIMIT;
  - clears on an IF grant;
  - clears on any IDLE cycle with if_req_valid=0.
- REQ: mem_req_valid=1 with the latched payload, held stable until mem_req_ready. On mem_req_ready, go to WAIT.
  - For an IF transaction: mem_wen=0, mem_wmask=0, mem_wdata=0.
- WAIT: mem_req_valid=0. On mem_resp_valid, go to IDLE and route the response in the same cycle:
  - owner D: d_resp_valid=1, d_rdata=mem_rdata.
  - owner IF and !killed and !if_kill: if_resp_valid=1, if_rdata = latched addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
  - owner IF and (killed or if_kill): no response pulse.
- if_kill:
  - in REQ/WAIT with owner IF, sets killed (sticky until the next grant);
  - in IDLE, blocks the IF grant that cycle;
  - has no effect on D transactions.
- Latency: grant at cycle T, mem_req_valid from T+1, earliest response at T+2. At most one grant every 3 cycles.
- The response cycle is always IDLE-exit; arbitration resumes on the next cycle (T+3 earliest). There is no back-to-back grant in the response cycle.
- Simultaneous IF and D valid at counter<STARVE_LIMIT: D wins. IF must hold if_req_valid and if_addr stable until if_req_ready or if_kill.
- Requesters must hold their payload stable while *_req_valid is high and *_req_ready is low.
- Reset mid-transaction: return to IDLE immediately with no response pulse. The downstream memory shares rst, so no stale response arrives.
- A mem_resp_valid in IDLE or REQ is a protocol error. Ignore it (no pulse); the bench flags it with an assertion.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2), owner encoding (OWN_IF=1'b0, OWN_D=1'b1), MEM_DATA_W=64, IF_WORD_W=32.
- One natural sub-module, mem_arb_pick: the combinational grant decision plus the starvation-counter next-state logic. This lets the fairness rule be unit-tested in isolation.

Test Plan:
1. Single fetch: if_addr=0x80000004, mem_req_ready=1 immediately, response 2 cycles later with mem_rdata=0x11112222_33334444 -> if_req_ready at T, mem_req_valid at T+1, if_resp_valid at T+2, if_rdata=0x11112222; d_resp_valid stays 0.
2. Simultaneous request: IF and D valid at T, d_wen=1, d_wmask=0x0F, d_wdata=0xDEADBEEF -> D granted at T, mem_wen=1 and mem_wmask=0x0F at T+1; IF granted only after the D response completes.
3. Starvation: IF held valid, D valid back-to-back, STARVE_LIMIT=4 -> exactly 4 D grants, then an IF grant on the 5th arbitration; counter reads 0 after it.
4. Kill in WAIT: IF granted, mem_req_ready=1, if_kill pulsed in WAIT, response 3 cycles later -> no if_resp_valid; state returns to IDLE; the next D request is granted on the following cycle.
5. Backpressure: D load, mem_req_ready held 0 for 5 cycles -> mem_req_valid high with mem_addr/mem_wen constant for all 5 cycles; WAIT entered the cycle after mem_req_ready=1; d_rdata equals mem_rdata.
6. Reset mid-transaction: rst asserted in REQ -> next cycle state=IDLE, all valid/ready outputs 0, counter=0; a fresh fetch after rst deasserts completes normally.
